wide_value_loader: RTL and testbench

Write-side counterpart to the public, reflected free-running value registers in the scope-map tests. It accepts a little-endian byte stream over a valid/ready interface and assembles a WIDTH-bit value in a shadow register. It commits that value atomically into a public register `value_q`, which otherwise toggles under control of an enable. It is instantiated per width (1 to 1024) beside the existing per-width instances, so that write paths get the same coverage as read paths.

---
 rtl/wide_value_loader.sv | 219 +++++++++++++++++++++
 tb/tb_wide_value_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_value_loader.sv
// wide_value_loader: assembles a little-endian byte stream into a WIDTH-bit
// shadow register and commits it atomically into value_q; value_q otherwise
// holds or inverts every cycle under toggle_en.
// Optional build macro WIDE_VALUE_LOADER_PARITY_EN adds even-parity checking
// (in_parity / err_parity); a frame with any parity mismatch is not committed.
module wide_value_loader #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    input  logic             toggle_en,
    output logic [WIDTH-1:0] value_q,
    output logic             commit,
    output logic             err_len
`ifdef WIDE_VALUE_LOADER_PARITY_EN
    ,
    input  logic             in_parity,
    output logic             err_parity
`endif
);

    localparam int unsigned NBYTES = (WIDTH + 7) / 8;
    localparam int unsigned SW     = NBYTES * 8;
    localparam int unsigned CW     = $clog2(NBYTES) + 1;
    localparam int unsigned NFULL  = WIDTH / 8;

    // Reset pattern: byte i = i for every complete byte, all remaining bits set.
    function automatic logic [SW-1:0] reset_pattern();
        logic [SW-1:0] p;
        p = '1;
        for (int unsigned i = 0; i < NFULL; i++) begin
            p[i*8 +: 8] = 8'(i);
        end
        return p;
    endfunction

    localparam logic [SW-1:0]    RST_SHADOW = reset_pattern();
    localparam logic [WIDTH-1:0] RST_VALUE  = RST_SHADOW[WIDTH-1:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_COMMIT
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   shadow_q, shadow_d;
    logic [WIDTH-1:0] value_d;
    logic            commit_q, commit_d;
    logic            err_len_q, err_len_d;
    logic            ready_q, ready_d;

    logic            accept;
    logic            wr_en;
    logic [CW-1:0]   wr_idx;
    logic            goto_commit;
    logic            last_slot;

`ifdef WIDE_VALUE_LOADER_PARITY_EN
    logic            bad_q, bad_d;
    logic            err_parity_q, err_parity_d;
    logic            byte_bad;
`endif

    assign in_ready = ready_q;
    assign commit   = commit_q;
    assign err_len  = err_len_q;
`ifdef WIDE_VALUE_LOADER_PARITY_EN
    assign err_parity = err_parity_q;
`endif

    // Next-state, shadow capture, value update and pulse generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        value_d     = toggle_en ? ~value_q : value_q;
        commit_d    = 1'b0;
        err_len_d   = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = '0;
        goto_commit = 1'b0;
        accept      = in_valid && ready_q;
        last_slot   = (cnt_q + CW'(1)) == CW'(NBYTES);
`ifdef WIDE_VALUE_LOADER_PARITY_EN
        bad_d        = bad_q;
        err_parity_d = 1'b0;
        byte_bad     = in_parity != (^in_data);
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wr_en  = 1'b1;
                    wr_idx = '0;
                    cnt_d  = CW'(1);
                    if (NBYTES == 1) begin
                        goto_commit = 1'b1;
                    end else if (in_last) begin
                        err_len_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    wr_en  = 1'b1;
                    wr_idx = cnt_q;
                    cnt_d  = cnt_q + CW'(1);
                    if (in_last) begin
                        if (last_slot) begin
                            goto_commit = 1'b1;
                        end else begin
                            err_len_d = 1'b1;
                            state_d   = S_IDLE;
                            cnt_d     = '0;
                        end
                    end else if (last_slot) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && in_last) begin
                    err_len_d = 1'b1;
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                end
            end
            S_COMMIT: begin
                value_d  = shadow_q[WIDTH-1:0];
                commit_d = 1'b1;
                state_d  = S_IDLE;
                cnt_d    = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A completed frame either commits or, if marked bad, is dropped.
        if (goto_commit) begin
`ifdef WIDE_VALUE_LOADER_PARITY_EN
            if (bad_q || byte_bad) begin
                err_parity_d = 1'b1;
                state_d      = S_IDLE;
                cnt_d        = '0;
            end else begin
                state_d = S_COMMIT;
            end
`else
            state_d = S_COMMIT;
`endif
        end

`ifdef WIDE_VALUE_LOADER_PARITY_EN
        if (accept && (state_q == S_LOAD)) begin
            bad_d = bad_q | byte_bad;
        end else if (accept && (state_q == S_IDLE)) begin
            bad_d = byte_bad;
        end
        if (state_d == S_IDLE) begin
            bad_d = 1'b0;
        end
`endif

        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (wr_en && (wr_idx == CW'(i))) begin
                shadow_d[i*8 +: 8] = in_data;
            end
        end

        ready_d = (state_d != S_COMMIT);
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shadow_q  <= RST_SHADOW;
            value_q   <= RST_VALUE;
            commit_q  <= 1'b0;
            err_len_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            value_q   <= value_d;
            commit_q  <= commit_d;
            err_len_q <= err_len_d;
            ready_q   <= ready_d;
        end
    end

`ifdef WIDE_VALUE_LOADER_PARITY_EN
    // Parity tracking registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bad_q        <= 1'b0;
            err_parity_q <= 1'b0;
        end else begin
            bad_q        <= bad_d;
            err_parity_q <= err_parity_d;
        end
    end
`endif

endmodule

// File: tb/tb_wide_value_loader.sv
// Directed bench for wide_value_loader across widths 33, 32, 7 and 1024.
module tb_wide_value_loader;

    logic CLK;
    logic RST_N;
    logic [7:0] in_data;
    logic in_last;
    logic par;
    logic par_flip;
    logic tog7;

    logic v33, v32, v7, v1k;
    logic rdy33, rdy32, rdy7, rdy1k;
    logic cm33, cm32, cm7, cm1k;
    logic el33, el32, el7, el1k;
    logic [32:0]   val33;
    logic [31:0]   val32;
    logic [6:0]    val7;
    logic [1023:0] val1k;
`ifdef WIDE_VALUE_LOADER_PARITY_EN
    logic ep33, ep32, ep7, ep1k;
`endif

    int n_vec;
    int n_err;

    logic [1023:0] exp_rst;
    logic [1023:0] exp_inv;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    wide_value_loader #(.WIDTH(33)) u33 (
        .CLK(CLK), .RST_N(RST_N), .in_valid(v33), .in_ready(rdy33),
        .in_data(in_data), .in_last(in_last), .toggle_en(1'b0),
        .value_q(val33), .commit(cm33), .err_len(el33)
`ifdef WIDE_VALUE_LOADER_PARITY_EN
        , .in_parity(par), .err_parity(ep33)
`endif
    );

    wide_value_loader #(.WIDTH(32)) u32 (
        .CLK(CLK), .RST_N(RST_N), .in_valid(v32), .in_ready(rdy32),
        .in_data(in_data), .in_last(in_last), .toggle_en(1'b0),
        .value_q(val32), .commit(cm32), .err_len(el32)
`ifdef WIDE_VALUE_LOADER_PARITY_EN
        , .in_parity(par), .err_parity(ep32)
`endif
    );

    wide_value_loader #(.WIDTH(7)) u7 (
        .CLK(CLK), .RST_N(RST_N), .in_valid(v7), .in_ready(rdy7),
        .in_data(in_data), .in_last(in_last), .toggle_en(tog7),
        .value_q(val7), .commit(cm7), .err_len(el7)
`ifdef WIDE_VALUE_LOADER_PARITY_EN
        , .in_parity(par), .err_parity(ep7)
`endif
    );

    wide_value_loader #(.WIDTH(1024)) u1k (
        .CLK(CLK), .RST_N(RST_N), .in_valid(v1k), .in_ready(rdy1k),
        .in_data(in_data), .in_last(in_last), .toggle_en(1'b0),
        .value_q(val1k), .commit(cm1k), .err_len(el1k)
`ifdef WIDE_VALUE_LOADER_PARITY_EN
        , .in_parity(par), .err_parity(ep1k)
`endif
    );

    function automatic logic sel_ready(input int dut);
        case (dut)
            33:      return rdy33;
            32:      return rdy32;
            7:       return rdy7;
            default: return rdy1k;
        endcase
    endfunction

    task automatic set_valid(input int dut, input logic v);
        v33 = (dut == 33) ? v : 1'b0;
        v32 = (dut == 32) ? v : 1'b0;
        v7  = (dut == 7)  ? v : 1'b0;
        v1k = (dut == 1024) ? v : 1'b0;
    endtask

    // Offer one byte to the selected instance; returns at the negedge after acceptance.
    task automatic put_byte(input int dut, input logic [7:0] d, input logic l);
        int g;
        g = 0;
        in_data = d;
        in_last = l;
        par     = (^d) ^ par_flip;
        set_valid(dut, 1'b1);
        while (!sel_ready(dut) && g < 50) begin
            @(negedge CLK);
            g++;
        end
        if (g >= 50) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout dut=%0d: in_ready stayed %b, required 1", dut, sel_ready(dut));
        end
        @(negedge CLK);
        set_valid(dut, 1'b0);
        in_last = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++; if (val33 !== 33'h1_0302_0100) begin n_err++; $display("FAIL rst_val33: got %h required %h", val33, 33'h1_0302_0100); end
        n_vec++; if (rdy33 !== 1'b1) begin n_err++; $display("FAIL rst_ready33: got %b required 1", rdy33); end
        n_vec++; if (cm33 !== 1'b0) begin n_err++; $display("FAIL rst_commit33: got %b required 0", cm33); end
        n_vec++; if (el33 !== 1'b0) begin n_err++; $display("FAIL rst_errlen33: got %b required 0", el33); end
        n_vec++; if (val32 !== 32'h0302_0100) begin n_err++; $display("FAIL rst_val32: got %h required 03020100", val32); end
        n_vec++; if (val7 !== 7'h7F) begin n_err++; $display("FAIL rst_val7: got %h required 7f", val7); end
        n_vec++; if (val1k !== exp_rst) begin n_err++; $display("FAIL rst_val1024: low got %h required %h", val1k[63:0], exp_rst[63:0]); end
    endtask

    task automatic test_frame32();
        put_byte(32, 8'hEF, 1'b0);
        put_byte(32, 8'hBE, 1'b0);
        put_byte(32, 8'hAD, 1'b0);
        put_byte(32, 8'hDE, 1'b1);
        n_vec++; if (rdy32 !== 1'b0) begin n_err++; $display("FAIL f32_ready_low: got %b required 0", rdy32); end
        n_vec++; if (cm32 !== 1'b0) begin n_err++; $display("FAIL f32_commit_early: got %b required 0", cm32); end
        n_vec++; if (val32 !== 32'h0302_0100) begin n_err++; $display("FAIL f32_val_early: got %h required 03020100", val32); end
        @(negedge CLK);
        n_vec++; if (val32 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL f32_val: got %h required deadbeef", val32); end
        n_vec++; if (cm32 !== 1'b1) begin n_err++; $display("FAIL f32_commit: got %b required 1", cm32); end
        n_vec++; if (rdy32 !== 1'b1) begin n_err++; $display("FAIL f32_ready_back: got %b required 1", rdy32); end
        @(negedge CLK);
        n_vec++; if (cm32 !== 1'b0) begin n_err++; $display("FAIL f32_commit_pulse: got %b required 0", cm32); end
    endtask

    task automatic test_toggle7();
        put_byte(7, 8'hFF, 1'b1);
        n_vec++; if (rdy7 !== 1'b0) begin n_err++; $display("FAIL t7_ready_low: got %b required 0", rdy7); end
        @(negedge CLK);
        n_vec++; if (cm7 !== 1'b1) begin n_err++; $display("FAIL t7_commit: got %b required 1", cm7); end
        n_vec++; if (val7 !== 7'h7F) begin n_err++; $display("FAIL t7_val0: got %h required 7f", val7); end
        tog7 = 1'b1;
        @(negedge CLK);
        n_vec++; if (val7 !== 7'h00) begin n_err++; $display("FAIL t7_val1: got %h required 00", val7); end
        @(negedge CLK);
        n_vec++; if (val7 !== 7'h7F) begin n_err++; $display("FAIL t7_val2: got %h required 7f", val7); end
        @(negedge CLK);
        n_vec++; if (val7 !== 7'h00) begin n_err++; $display("FAIL t7_val3: got %h required 00", val7); end
        tog7 = 1'b0;
        @(negedge CLK);
        n_vec++; if (val7 !== 7'h00) begin n_err++; $display("FAIL t7_hold: got %h required 00", val7); end
        // Toggle active on the accept edge, ignored on the commit edge.
        tog7 = 1'b1;
        put_byte(7, 8'hD5, 1'b1);
        n_vec++; if (val7 !== 7'h7F) begin n_err++; $display("FAIL t7_tog_accept: got %h required 7f", val7); end
        @(negedge CLK);
        tog7 = 1'b0;
        n_vec++; if (val7 !== 7'h55) begin n_err++; $display("FAIL t7_commit_prio: got %h required 55", val7); end
    endtask

    task automatic test_len_err32();
        put_byte(32, 8'h99, 1'b1);
        n_vec++; if (el32 !== 1'b1) begin n_err++; $display("FAIL len_single: got %b required 1", el32); end
        put_byte(32, 8'h11, 1'b0);
        n_vec++; if (el32 !== 1'b0) begin n_err++; $display("FAIL len_single_pulse: got %b required 0", el32); end
        put_byte(32, 8'h22, 1'b0);
        put_byte(32, 8'h33, 1'b1);
        n_vec++; if (el32 !== 1'b1) begin n_err++; $display("FAIL len_short: got %b required 1", el32); end
        n_vec++; if (cm32 !== 1'b0) begin n_err++; $display("FAIL len_short_commit: got %b required 0", cm32); end
        @(negedge CLK);
        n_vec++; if (el32 !== 1'b0) begin n_err++; $display("FAIL len_short_pulse: got %b required 0", el32); end
        n_vec++; if (val32 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL len_short_val: got %h required deadbeef", val32); end
        for (int i = 1; i <= 5; i++) put_byte(32, 8'(i), 1'b0);
        n_vec++; if (el32 !== 1'b0) begin n_err++; $display("FAIL len_long_early: got %b required 0", el32); end
        put_byte(32, 8'h06, 1'b1);
        n_vec++; if (el32 !== 1'b1) begin n_err++; $display("FAIL len_long: got %b required 1", el32); end
        @(negedge CLK);
        n_vec++; if (cm32 !== 1'b0) begin n_err++; $display("FAIL len_long_commit: got %b required 0", cm32); end
        n_vec++; if (val32 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL len_long_val: got %h required deadbeef", val32); end
        put_byte(32, 8'h78, 1'b0);
        put_byte(32, 8'h56, 1'b0);
        put_byte(32, 8'h34, 1'b0);
        put_byte(32, 8'h12, 1'b1);
        @(negedge CLK);
        n_vec++; if (cm32 !== 1'b1) begin n_err++; $display("FAIL len_recover_commit: got %b required 1", cm32); end
        n_vec++; if (val32 !== 32'h1234_5678) begin n_err++; $display("FAIL len_recover_val: got %h required 12345678", val32); end
    endtask

`ifdef WIDE_VALUE_LOADER_PARITY_EN
    task automatic test_parity32();
        put_byte(32, 8'hA1, 1'b0);
        par_flip = 1'b1;
        put_byte(32, 8'hB2, 1'b0);
        par_flip = 1'b0;
        put_byte(32, 8'hC3, 1'b0);
        put_byte(32, 8'hD4, 1'b1);
        n_vec++; if (ep32 !== 1'b1) begin n_err++; $display("FAIL par_err: got %b required 1", ep32); end
        n_vec++; if (el32 !== 1'b0) begin n_err++; $display("FAIL par_errlen: got %b required 0", el32); end
        n_vec++; if (rdy32 !== 1'b1) begin n_err++; $display("FAIL par_ready: got %b required 1", rdy32); end
        @(negedge CLK);
        n_vec++; if (ep32 !== 1'b0) begin n_err++; $display("FAIL par_pulse: got %b required 0", ep32); end
        n_vec++; if (cm32 !== 1'b0) begin n_err++; $display("FAIL par_commit: got %b required 0", cm32); end
        n_vec++; if (val32 !== 32'h1234_5678) begin n_err++; $display("FAIL par_val: got %h required 12345678", val32); end
    endtask
`endif

    task automatic send_frame1k(input logic inv, input int nbytes, input logic with_last);
        for (int i = 0; i < nbytes; i++) begin
            if ($urandom_range(0, 1) == 1) @(negedge CLK);
            put_byte(1024, inv ? 8'(255 - i) : 8'(i), with_last && (i == nbytes - 1));
        end
    endtask

    task automatic test_back_to_back();
        send_frame1k(1'b1, 128, 1'b1);
        n_vec++; if (rdy1k !== 1'b0) begin n_err++; $display("FAIL b2b_ready_low: got %b required 0", rdy1k); end
        @(negedge CLK);
        n_vec++; if (cm1k !== 1'b1) begin n_err++; $display("FAIL b2b_commit1: got %b required 1", cm1k); end
        n_vec++; if (val1k !== exp_inv) begin n_err++; $display("FAIL b2b_val1: low got %h required %h", val1k[63:0], exp_inv[63:0]); end
        send_frame1k(1'b0, 60, 1'b0);
        n_vec++; if (val1k !== exp_inv) begin n_err++; $display("FAIL b2b_partial_val: low got %h required %h", val1k[63:0], exp_inv[63:0]); end
        RST_N = 1'b0;
        #1;
        n_vec++; if (val1k !== exp_rst) begin n_err++; $display("FAIL b2b_reset_val: low got %h required %h", val1k[63:0], exp_rst[63:0]); end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            n_vec++; if (cm1k !== 1'b0 || el1k !== 1'b0) begin n_err++; $display("FAIL b2b_abort_pulse: commit %b err_len %b required 0 0", cm1k, el1k); end
        end
        n_vec++; if (rdy1k !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after_rst: got %b required 1", rdy1k); end
        send_frame1k(1'b0, 128, 1'b1);
        @(negedge CLK);
        n_vec++; if (cm1k !== 1'b1) begin n_err++; $display("FAIL b2b_commit2: got %b required 1", cm1k); end
        n_vec++; if (val1k !== exp_rst) begin n_err++; $display("FAIL b2b_val2: low got %h required %h", val1k[63:0], exp_rst[63:0]); end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        RST_N    = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        par      = 1'b0;
        par_flip = 1'b0;
        tog7     = 1'b0;
        set_valid(0, 1'b0);
        for (int i = 0; i < 128; i++) begin
            exp_rst[i*8 +: 8] = 8'(i);
            exp_inv[i*8 +: 8] = 8'(255 - i);
        end
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        test_reset();
        test_frame32();
        test_toggle7();
        test_len_err32();
`ifdef WIDE_VALUE_LOADER_PARITY_EN
        test_parity32();
`endif
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
